disparity_wta: RTL and testbench
================================

// Module: disparity_wta
// PURPOSE
//   Winner-takes-all stage directly downstream of aggregate_cost. Takes one pixel's
//   aggregated cost vector (DISP_RANGE x PIXEL_WIDTH) per cycle.
//   Finds the minimum cost with a pipelined binary compare tree.
//   Emits the winning disparity (MIN_DISPARITY + index) with its row/col.
//   Emits min_cost, which also feeds back as aggregate_cost's min_aggr_last.
// PARAMETERS
//   MIN_DISPARITY   20    disparity represented by cost index 0
//   DISP_RANGE      108   number of costs per pixel; supported range 2..128
//   PIXEL_WIDTH     8     width of one cost and of min_cost
//   INVALID_THRESH  200   min_cost above this marks pixel invalid (macro only)
// PORTS
//   clk          in   1                       rising-edge clock
//   rst          in   1                       asynchronous, active-low reset
//   in_valid     in   1                       cost_aggr/in_row/in_col valid this cycle
//   cost_aggr    in   DISP_RANGE*PIXEL_WIDTH  cost d at [PIXEL_WIDTH*d +: PIXEL_WIDTH]
//   in_row       in   10                      pixel row
//   in_col       in   10                      pixel column
//   out_valid    out  1                       result valid, one-cycle pulse per pixel
//   disp_out     out  8                       MIN_DISPARITY + winning index
//   min_cost     out  PIXEL_WIDTH             winning cost value
//   out_row      out  10                      row aligned to result
//   out_col      out  10                      column aligned to result
//   out_invalid  out  1                       only with WTA_INVALID_THRESH_EN
// BEHAVIOUR
//   Clock and reset
//   - Single clock domain; no backpressure; accepts one pixel every cycle.
//   - rst low: every register and output clears immediately (asynchronous):
//     out_valid=0, disp_out=0, min_cost=0, out_row=0, out_col=0, out_invalid=0.
//   Pipeline and latency
//   - Stage 0 registers inputs. Stages 1..L each halve the candidate count.
//   - L = ceil(log2(DISP_RANGE)); for 108: 108>54>27>14>7>4>2>1, L=7.
//   - Latency = 1+L cycles: in_valid at edge N gives out_valid at edge N+8 (default).
//   - Each stage carries a valid bit, row/col and {cost, index(7b)} per candidate.
//   - Stage data registers load only when that stage's incoming valid=1.
//   - Otherwise data holds: outputs keep the last result while out_valid=0.
//   - Valid bits shift every cycle.
//   Compare rules
//   - Each pair compares (a = lower index, b = higher index).
//   - Winner is b only if cost_b < cost_a (strict), so ties go to the lower index.
//   - With an odd candidate count, the last candidate passes through unchanged.
//   - Comparisons are unsigned. No arithmetic on costs.
//   - disp_out = MIN_DISPARITY + index, 8-bit (max 20+107=127, no overflow).
//   Boundaries
//   - All costs equal: index 0 wins.
//   - All costs 255: min_cost=255.
//   - Gaps in in_valid produce matching gaps in out_valid, order preserved.
//   - Reset during flight: in-flight pixels are dropped.
//   - After reset release, no out_valid until a new pixel has passed through 1+L stages.
// CONFIGURATION
//   WTA_INVALID_THRESH_EN defined:
//   - Adds port out_invalid.
//   - At the final stage, if min_cost > INVALID_THRESH: out_invalid=1 and disp_out=0.
//   - min_cost still reports the true minimum. Latency unchanged.
//   WTA_INVALID_THRESH_EN undefined:
//   - Port out_invalid absent.
//   - disp_out is always MIN_DISPARITY + index.
// TESTING
//   1 Costs 255 except idx37=5, valid 1 cycle
//     -> after 8 cycles: out_valid=1 for 1 cycle, disp_out=57, min_cost=5, row/col echoed.
//   2 idx10=3 and idx90=3, rest 100 -> disp_out=30, min_cost=3 (tie to lower).
//     Repeat with only idx107=0 -> disp_out=127.
//   3 Stream 400 consecutive pixels, random costs, row=0, col 0..399
//     -> out_valid high 400 cycles; every result matches a reference model; cols in order.
//   4 Pixel A, 3 idle cycles, pixel B
//     -> out_valid pattern 1,0,0,0,1; outputs hold A's values during the gap.
//   5 rst low at cycle 4 of a 5-pixel stream, high at cycle 6
//     -> all outputs 0 at once; no out_valid for dropped pixels.
//     -> next pixel emerges exactly 8 cycles after it is accepted.
//   6 All costs 220, INVALID_THRESH=200
//     -> with macro: out_invalid=1, disp_out=0, min_cost=220.
//     -> without macro: disp_out=20, min_cost=220.

Source files
------------

// File: rtl/disparity_wta.sv
// Winner-takes-all disparity stage: a pipelined binary min-tree over one pixel's cost vector.
// Optional macro WTA_INVALID_THRESH_EN adds out_invalid and suppresses disparities whose minimum cost is too high.
module disparity_wta #(
  parameter int MIN_DISPARITY  = 20,
  parameter int DISP_RANGE     = 108,
  parameter int PIXEL_WIDTH    = 8
`ifdef WTA_INVALID_THRESH_EN
  , parameter int INVALID_THRESH = 200
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [DISP_RANGE*PIXEL_WIDTH-1:0] cost_aggr,
  input  logic [9:0]                        in_row,
  input  logic [9:0]                        in_col,
  output logic                              out_valid,
  output logic [7:0]                        disp_out,
  output logic [PIXEL_WIDTH-1:0]            min_cost,
  output logic [9:0]                        out_row,
  output logic [9:0]                        out_col
`ifdef WTA_INVALID_THRESH_EN
  , output logic                            out_invalid
`endif
);

  localparam int IDX_W  = 7;
  localparam int LEVELS = $clog2(DISP_RANGE);

  typedef logic [PIXEL_WIDTH-1:0] cost_t;
  typedef logic [IDX_W-1:0]       idx_t;

  // Number of surviving candidates after lvl halving stages (odd counts round up).
  function automatic int cand_cnt(input int lvl);
    int n;
    n = DISP_RANGE;
    for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int N = cand_cnt(k);

    logic       vld;
    logic [9:0] row;
    logic [9:0] col;
    cost_t      cost [N];
    idx_t       idx  [N];

    if (k == 0) begin : g_in
      // NOTE: the cost arrays are reset along with the control bits so that a reset clears every output at once.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld <= 1'b0;
          row <= '0;
          col <= '0;
          for (int d = 0; d < N; d++) cost[d] <= '0;
        end else begin
          vld <= in_valid;
          if (in_valid) begin
            row <= in_row;
            col <= in_col;
            for (int d = 0; d < N; d++) cost[d] <= cost_aggr[PIXEL_WIDTH*d +: PIXEL_WIDTH];
          end
        end
      end

      // Stage 0 indices are the candidate positions themselves, so no storage is needed.
      for (genvar d = 0; d < N; d++) begin : g_idx
        assign idx[d] = IDX_W'(d);
      end
    end else begin : g_cmp
      localparam int NP = cand_cnt(k - 1);

      cost_t nxt_cost [N];
      idx_t  nxt_idx  [N];

      for (genvar j = 0; j < N; j++) begin : g_node
        if (2*j + 1 < NP) begin : g_pair
          // Strict less-than keeps the lower index on ties.
          logic pick_b;
          assign pick_b      = g_lvl[k-1].cost[2*j+1] < g_lvl[k-1].cost[2*j];
          assign nxt_cost[j] = pick_b ? g_lvl[k-1].cost[2*j+1] : g_lvl[k-1].cost[2*j];
          assign nxt_idx[j]  = pick_b ? g_lvl[k-1].idx[2*j+1]  : g_lvl[k-1].idx[2*j];
        end else begin : g_pass
          assign nxt_cost[j] = g_lvl[k-1].cost[2*j];
          assign nxt_idx[j]  = g_lvl[k-1].idx[2*j];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld <= 1'b0;
          row <= '0;
          col <= '0;
          for (int d = 0; d < N; d++) begin
            cost[d] <= '0;
            idx[d]  <= '0;
          end
        end else begin
          vld <= g_lvl[k-1].vld;
          if (g_lvl[k-1].vld) begin
            row  <= g_lvl[k-1].row;
            col  <= g_lvl[k-1].col;
            cost <= nxt_cost;
            idx  <= nxt_idx;
          end
        end
      end
    end
  end

  // Until the first result has left the tree, disp_out must read 0 rather than MIN_DISPARITY.
  logic       has_result;
  logic       result_shown;
  logic [7:0] disp_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           has_result <= 1'b0;
    else if (out_valid) has_result <= 1'b1;
  end

  assign result_shown = has_result | out_valid;
  assign disp_raw     = 8'(MIN_DISPARITY) + 8'(g_lvl[LEVELS].idx[0]);

  assign out_valid = g_lvl[LEVELS].vld;
  assign min_cost  = g_lvl[LEVELS].cost[0];
  assign out_row   = g_lvl[LEVELS].row;
  assign out_col   = g_lvl[LEVELS].col;

`ifdef WTA_INVALID_THRESH_EN
  assign out_invalid = min_cost > cost_t'(INVALID_THRESH);
  assign disp_out    = (result_shown && !out_invalid) ? disp_raw : 8'd0;
`else
  assign disp_out    = result_shown ? disp_raw : 8'd0;
`endif

endmodule

// File: tb/tb_disparity_wta.sv
// Self-checking bench for disparity_wta: table vectors, gap and reset sequences, random stream,
// all results compared through an expected-result queue.
module tb_disparity_wta;

  localparam int DR    = 108;
  localparam int PW    = 8;
  localparam int MIN_D = 20;
`ifdef WTA_INVALID_THRESH_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DR*PW-1:0]  cost_aggr = '0;
  logic [9:0]        in_row = '0;
  logic [9:0]        in_col = '0;
  logic              out_valid;
  logic [7:0]        disp_out;
  logic [PW-1:0]     min_cost;
  logic [9:0]        out_row;
  logic [9:0]        out_col;
  logic              out_invalid;

  disparity_wta dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .cost_aggr (cost_aggr),
    .in_row    (in_row),
    .in_col    (in_col),
    .out_valid (out_valid),
    .disp_out  (disp_out),
    .min_cost  (min_cost),
    .out_row   (out_row),
    .out_col   (out_col)
`ifdef WTA_INVALID_THRESH_EN
    , .out_invalid (out_invalid)
`endif
  );

`ifndef WTA_INVALID_THRESH_EN
  assign out_invalid = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    disp;
    logic [PW-1:0] cost;
    logic [9:0]    row;
    logic [9:0]    col;
    logic          inv;
  } exp_t;

  typedef struct {
    int base;
    int i1;
    int v1;
    int i2;
    int v2;
    int exp_disp;
    int exp_min;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  int   max_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first strict minimum scanning upward, then the optional threshold rule.
  function automatic exp_t model(input logic [DR*PW-1:0] vec, input logic [9:0] row, input logic [9:0] col);
    exp_t e;
    int   best;
    int   bi;
    best = int'(vec[PW-1:0]);
    bi   = 0;
    for (int d = 1; d < DR; d++) begin
      if (int'(vec[PW*d +: PW]) < best) begin
        best = int'(vec[PW*d +: PW]);
        bi   = d;
      end
    end
    e.cost = PW'(best);
    e.inv  = INV_EN && (best > 200);
    e.disp = e.inv ? 8'd0 : 8'(MIN_D + bi);
    e.row  = row;
    e.col  = col;
    return e;
  endfunction

  function automatic exp_t from_table(input vec_t v, input logic [9:0] row, input logic [9:0] col);
    exp_t e;
    e.cost = PW'(v.exp_min);
    e.inv  = INV_EN && (v.exp_min > 200);
    e.disp = e.inv ? 8'd0 : 8'(v.exp_disp);
    e.row  = row;
    e.col  = col;
    return e;
  endfunction

  function automatic logic [DR*PW-1:0] build_vec(input vec_t v);
    logic [DR*PW-1:0] vec;
    for (int d = 0; d < DR; d++) vec[PW*d +: PW] = PW'(v.base);
    if (v.i1 >= 0) vec[PW*v.i1 +: PW] = PW'(v.v1);
    if (v.i2 >= 0) vec[PW*v.i2 +: PW] = PW'(v.v2);
    return vec;
  endfunction

  task automatic drive(input logic [DR*PW-1:0] vec, input logic [9:0] row, input logic [9:0] col, input exp_t e);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    cost_aggr = vec;
    in_row    = row;
    in_col    = col;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  // Scoreboard monitor: compares every emitted result against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) run_len++;
    else           run_len = 0;
    if (run_len > max_run) max_run = run_len;
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("disp_out", disp_out, e.disp);
        check("min_cost", min_cost, e.cost);
        check("out_row", out_row, e.row);
        check("out_col", out_col, e.col);
        check("out_invalid", out_invalid, e.inv);
      end
    end
  end

  vec_t tbl[10];

  initial begin
    exp_t             ea;
    logic [DR*PW-1:0] vec;
    int               pat[5];
    int               seen;
    int               first_k;

    tbl[0] = '{255, 37,   5,  -1,   0,  57,   5};
    tbl[1] = '{100, 10,   3,  90,   3,  30,   3};
    tbl[2] = '{100, 107,  0,  -1,   0, 127,   0};
    tbl[3] = '{ 50, -1,   0,  -1,   0,  20,  50};
    tbl[4] = '{255, -1,   0,  -1,   0,  20, 255};
    tbl[5] = '{220, -1,   0,  -1,   0,  20, 220};
    tbl[6] = '{  8,  0,   7,  -1,   0,  20,   7};
    tbl[7] = '{  9,  1,   8,   2,   8,  21,   8};
    tbl[8] = '{200, 106, 200, 53, 199,  73, 199};
    tbl[9] = '{201, -1,   0,  -1,   0,  20, 201};

    // Reset state
    #2 rst = 1'b0;
    #10;
    check("rst_out_valid", out_valid, 0);
    check("rst_disp_out", disp_out, 0);
    check("rst_min_cost", min_cost, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_invalid", out_invalid, 0);
    @(negedge clk);
    rst = 1'b1;

    // Table vectors, back to back
    for (int i = 0; i < 10; i++) begin
      drive(build_vec(tbl[i]), 10'(i + 1), 10'(3*i + 5), from_table(tbl[i], 10'(i + 1), 10'(3*i + 5)));
    end
    idle(12);
    drain();

    // Pixel A, three idle cycles, pixel B: valid pattern 1,0,0,0,1 with A held in the gap
    ea = from_table(tbl[0], 10'd300, 10'd301);
    drive(build_vec(tbl[0]), 10'd300, 10'd301, ea);
    idle(3);
    drive(build_vec(tbl[1]), 10'd302, 10'd303, from_table(tbl[1], 10'd302, 10'd303));
    idle(4);
    pat = '{1, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gap_valid_pattern", out_valid, pat[i]);
      if (i > 0 && i < 4) begin
        check("gap_hold_disp", disp_out, ea.disp);
        check("gap_hold_min", min_cost, ea.cost);
        check("gap_hold_col", out_col, ea.col);
      end
    end
    idle(2);
    drain();

    // Reset during a 5-pixel stream: in-flight pixels are dropped
    for (int i = 0; i < 5; i++) begin
      vec = build_vec(tbl[i]);
      drive(vec, 10'd400, 10'(i), model(vec, 10'd400, 10'(i)));
    end
    #2;
    rst      = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_disp_out", disp_out, 0);
    check("midrst_min_cost", min_cost, 0);
    check("midrst_out_row", out_row, 0);
    check("midrst_out_col", out_col, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_dropped_output", seen, 0);

    // Latency after reset: output exactly 8 edges after the accepting edge's drive cycle
    vec = build_vec(tbl[8]);
    drive(vec, 10'd500, 10'd501, model(vec, 10'd500, 10'd501));
    first_k = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      if (out_valid && first_k < 0) first_k = k;
    end
    check("post_reset_latency", first_k, 8);
    drain();

    // Random stream of 400 consecutive pixels
    max_run = 0;
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < DR; d++) vec[PW*d +: PW] = PW'($urandom_range(0, 255));
      drive(vec, 10'd0, 10'(c), model(vec, 10'd0, 10'(c)));
    end
    idle(12);
    drain();
    check("stream_valid_run", max_run, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got %0d checks expected completion", checks);
    $fatal(1, "timeout");
  end

endmodule
